// File: rtl/alu_mem_unit_pkg.sv
// Shared constants for the ALU + data-memory slice: datapath width,
// ALU operation codes and load-type codes.
package alu_mem_unit_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } ld_type_e;

endpackage

// File: rtl/alu_mem_unit_if.sv
// Bus bundle for alu_mem_unit: ALU operands/results, memory controls,
// load result and the debug read port. master drives, slave is the unit.
interface alu_mem_unit_if
    import alu_mem_unit_pkg::*;
#(
    parameter int DATA_WIDTH = alu_mem_unit_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 12
);
    logic [3:0]            alu_ctrl;
    logic                  alu_src;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [DATA_WIDTH-1:0] sign_ext;
    logic [DATA_WIDTH-1:0] results;
    logic                  zero;
    logic                  res_last_bit;
    logic                  mem_write;
    logic                  mem_read;
    logic [3:0]            byte_enb;
    logic [DATA_WIDTH-1:0] w_dat;
    logic [2:0]            func3;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  valid;
    logic [ADDR_WIDTH-1:0] debug_addr;
    logic [DATA_WIDTH-1:0] debug_data;

    modport master (
        output alu_ctrl, alu_src, src1, src2, sign_ext,
        output mem_write, mem_read, byte_enb, w_dat, func3, debug_addr,
        input  results, zero, res_last_bit, wb_data, valid, debug_data
    );

    modport slave (
        input  alu_ctrl, alu_src, src1, src2, sign_ext,
        input  mem_write, mem_read, byte_enb, w_dat, func3, debug_addr,
        output results, zero, res_last_bit, wb_data, valid, debug_data
    );

endinterface

// File: rtl/alu_mem_unit_bram32.sv
// Word-organised data memory: one synchronous byte-enabled write port,
// one asynchronous read port and one asynchronous debug read port.
// Contents are never cleared.
module bram32
    import alu_mem_unit_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [31:0]      wdata_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [31:0]      rdata_o,
    input  logic [IDX_W-1:0] dbg_idx_i,
    output logic [31:0]      dbg_data_o
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane write; unselected lanes keep their old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[wr_idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Asynchronous reads see the pre-edge contents during a write cycle.
    assign rdata_o    = mem_q[rd_idx_i];
    assign dbg_data_o = mem_q[dbg_idx_i];

endmodule

// File: rtl/alu_mem_unit.sv
// Single-cycle ALU with an attached data memory. The ALU result doubles as
// the memory byte address; loads are extracted and extended by a
// combinational byte reader.
module alu_mem_unit
    import alu_mem_unit_pkg::*;
#(
    parameter int DATA_WIDTH = alu_mem_unit_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 1024
) (
    input  logic          clk,
    input  logic          rst,
    alu_mem_unit_if.slave bus
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  mem_we;
    logic [31:0]           ram_rd;
    logic [31:0]           r_dat;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_valid;
    logic                  unused_dbg_lsb;

    assign op_b  = bus.alu_src ? bus.sign_ext : bus.src2;
    assign shamt = op_b[4:0];

    // ALU: pure function of the operands, independent of reset.
    always_comb begin
        alu_res = '0;
        case (bus.alu_ctrl)
            ALU_ADD:  alu_res = bus.src1 + op_b;
            ALU_SUB:  alu_res = bus.src1 - op_b;
            ALU_AND:  alu_res = bus.src1 & op_b;
            ALU_OR:   alu_res = bus.src1 | op_b;
            ALU_XOR:  alu_res = bus.src1 ^ op_b;
            ALU_SLL:  alu_res = bus.src1 << shamt;
            ALU_SRL:  alu_res = bus.src1 >> shamt;
            ALU_SRA:  alu_res = $signed(bus.src1) >>> shamt;
            ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.src1) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, bus.src1 < op_b};
            default:  alu_res = '0;
        endcase
    end

    assign bus.results      = alu_res;
    assign bus.zero         = (alu_res == '0);
    assign bus.res_last_bit = alu_res[0];

    // Reset cancels any write in flight and blanks the read data path.
    assign mem_we = bus.mem_write & ~rst;
    assign r_dat  = (bus.mem_read && !rst) ? ram_rd : 32'h0;

    bram32 #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_bram32 (
        .clk        (clk),
        .we_i       (mem_we),
        .be_i       (bus.byte_enb),
        .wr_idx_i   (alu_res[ADDR_WIDTH-1:2]),
        .wdata_i    (bus.w_dat),
        .rd_idx_i   (alu_res[ADDR_WIDTH-1:2]),
        .rdata_o    (ram_rd),
        .dbg_idx_i  (bus.debug_addr[ADDR_WIDTH-1:2]),
        .dbg_data_o (bus.debug_data)
    );

    // Debug port is word addressed; the byte offset is ignored.
    assign unused_dbg_lsb = ^bus.debug_addr[1:0];

    // Byte reader: legal func3/lane-mask pairs select and extend a field,
    // anything else yields zero with valid low.
    always_comb begin
        ld_valid = 1'b0;
        ld_data  = '0;
        byte_sel = 8'h0;
        half_sel = 16'h0;
        case (bus.func3)
            LD_LB, LD_LBU: begin
                ld_valid = 1'b1;
                case (bus.byte_enb)
                    4'b0001: byte_sel = r_dat[7:0];
                    4'b0010: byte_sel = r_dat[15:8];
                    4'b0100: byte_sel = r_dat[23:16];
                    4'b1000: byte_sel = r_dat[31:24];
                    default: ld_valid = 1'b0;
                endcase
                if (ld_valid)
                    ld_data = {{(DATA_WIDTH-8){byte_sel[7] & ~bus.func3[2]}}, byte_sel};
            end
            LD_LH, LD_LHU: begin
                ld_valid = 1'b1;
                case (bus.byte_enb)
                    4'b0011: half_sel = r_dat[15:0];
                    4'b1100: half_sel = r_dat[31:16];
                    default: ld_valid = 1'b0;
                endcase
                if (ld_valid)
                    ld_data = {{(DATA_WIDTH-16){half_sel[15] & ~bus.func3[2]}}, half_sel};
            end
            LD_LW: begin
                if (bus.byte_enb == 4'b1111) begin
                    ld_valid = 1'b1;
                    ld_data  = r_dat;
                end
            end
            default: begin
                ld_valid = 1'b0;
                ld_data  = '0;
            end
        endcase
    end

    assign bus.wb_data = ld_data;
    assign bus.valid   = ld_valid;

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: directed spec cases plus randomized
// ALU and memory traffic compared against a behavioural model.
module tb_alu_mem_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mem_unit_if bus ();

    alu_mem_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] ref_mem [0:1023];

    // Reference ALU from the operation definitions.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Reference load extraction from a whole word.
    task automatic load_ref(input logic [2:0] f3, input logic [3:0] be, input logic [31:0] w,
                            output logic [31:0] d, output logic v);
        logic [7:0]  by;
        logic [15:0] h;
        int k;
        d = 32'h0;
        v = 1'b0;
        k = 0;
        if ((f3 == 3'd0 || f3 == 3'd4) && $countones(be) == 1) begin
            for (int i = 0; i < 4; i++) if (be[i]) k = i;
            by = w[8*k +: 8];
            v  = 1'b1;
            d  = (f3 == 3'd0 && by[7]) ? (32'hFFFF_FF00 | {24'h0, by}) : {24'h0, by};
        end else if ((f3 == 3'd1 || f3 == 3'd5) && (be == 4'b0011 || be == 4'b1100)) begin
            h = (be == 4'b0011) ? w[15:0] : w[31:16];
            v = 1'b1;
            d = (f3 == 3'd1 && h[15]) ? (32'hFFFF_0000 | {16'h0, h}) : {16'h0, h};
        end else if (f3 == 3'd2 && be == 4'b1111) begin
            v = 1'b1;
            d = w;
        end
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic sel);
        bus.alu_ctrl = op;
        bus.src1     = a;
        bus.src2     = b;
        bus.sign_ext = imm;
        bus.alu_src  = sel;
    endtask

    // Address a word through ADD; junk in bits outside the word index.
    task automatic set_addr(input logic [9:0] idx);
        logic [31:0] r;
        r = $urandom;
        set_alu(4'd0, {r[31:12], idx, r[1:0]}, $urandom, 32'h0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_alu(4'd0, 32'd7, 32'd9, 32'h0, 1'b0);
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.func3     = 3'b010;
        bus.byte_enb  = 4'b1111;
        #1;
        total++;
        if (bus.wb_data !== 32'h0 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_load: wb=%h valid=%b want wb=0 valid=1", bus.wb_data, bus.valid);
        end
        total++;
        if (bus.results !== 32'd16) begin
            bad++;
            $display("FAIL reset_alu: results=%h want 00000010", bus.results);
        end
        bus.func3 = 3'b011;
        #1;
        total++;
        if (bus.valid !== 1'b0 || bus.wb_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_illegal: wb=%h valid=%b want 0/0", bus.wb_data, bus.valid);
        end
        tick();
        rst = 1'b0;
        bus.mem_read = 1'b0;
    endtask

    task automatic test_alu_directed();
        logic [3:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] res [4];
        logic        zs  [4];
        logic        ls  [4];
        ops = '{4'd0, 4'd8, 4'd9, 4'd1};
        as  = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5};
        bs  = '{32'd3, 32'd1, 32'd1, 32'd5};
        res = '{32'd8, 32'd1, 32'd0, 32'd0};
        zs  = '{1'b0, 1'b0, 1'b1, 1'b1};
        ls  = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_alu(ops[i], as[i], bs[i], 32'hDEAD_BEEF, 1'b0);
            #1;
            total++;
            if (bus.results !== res[i] || bus.zero !== zs[i] || bus.res_last_bit !== ls[i]) begin
                bad++;
                $display("FAIL alu_directed[%0d]: res=%h z=%b l=%b want res=%h z=%b l=%b",
                         i, bus.results, bus.zero, bus.res_last_bit, res[i], zs[i], ls[i]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [3:0]  op;
        logic [31:0] a, b, imm, exp;
        logic        sel;
        for (int i = 0; i < 300; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            imm = $urandom;
            sel = 1'($urandom_range(0, 1));
            if (i % 10 == 0) b = a;
            if (i % 10 == 1) imm = a;
            if (i % 10 == 2) begin
                b[4:0]   = 5'd31;
                imm[4:0] = 5'd31;
            end
            set_alu(op, a, b, imm, sel);
            exp = alu_ref(op, a, sel ? imm : b);
            #1;
            total++;
            if (bus.results !== exp || bus.zero !== (exp == 32'h0) || bus.res_last_bit !== exp[0]) begin
                bad++;
                $display("FAIL alu_random op=%h a=%h b=%h: res=%h z=%b l=%b want %h",
                         op, a, sel ? imm : b, bus.results, bus.zero, bus.res_last_bit, exp);
            end
        end
    endtask

    task automatic test_word_store();
        set_alu(4'd0, 32'h0, 32'h0, 32'hC, 1'b1);
        bus.mem_write = 1'b1;
        bus.mem_read  = 1'b0;
        bus.byte_enb  = 4'b1111;
        bus.w_dat     = 32'h0000_000A;
        tick();
        ref_mem[3] = 32'h0000_000A;
        bus.mem_write  = 1'b0;
        bus.debug_addr = 12'h00C;
        #1;
        total++;
        if (bus.debug_data !== 32'h0000_000A) begin
            bad++;
            $display("FAIL word_debug: got %h want 0000000a", bus.debug_data);
        end
        bus.mem_read = 1'b1;
        bus.func3    = 3'b010;
        #1;
        total++;
        if (bus.wb_data !== 32'h0000_000A || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL word_load: wb=%h valid=%b want 0000000a/1", bus.wb_data, bus.valid);
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_byte_store();
        set_alu(4'd0, 32'h0, 32'h0, 32'h4, 1'b1);
        bus.mem_write = 1'b1;
        bus.byte_enb  = 4'b1111;
        bus.w_dat     = 32'h1122_3344;
        tick();
        bus.byte_enb  = 4'b0010;
        bus.w_dat     = 32'h0000_8000;
        tick();
        ref_mem[1] = 32'h1122_8044;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.func3     = 3'b000;
        #1;
        total++;
        if (bus.wb_data !== 32'hFFFF_FF80 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL byte_lb: wb=%h valid=%b want ffffff80/1", bus.wb_data, bus.valid);
        end
        bus.func3 = 3'b100;
        #1;
        total++;
        if (bus.wb_data !== 32'h0000_0080 || bus.valid !== 1'b1) begin
            bad++;
            $display("FAIL byte_lbu: wb=%h valid=%b want 00000080/1", bus.wb_data, bus.valid);
        end
        bus.debug_addr = 12'h004;
        #1;
        total++;
        if (bus.debug_data !== 32'h1122_8044) begin
            bad++;
            $display("FAIL byte_lanes: got %h want 11228044", bus.debug_data);
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_illegal();
        logic [2:0] f3s [5];
        logic [3:0] bes [5];
        f3s = '{3'b001, 3'b011, 3'b110, 3'b111, 3'b010};
        bes = '{4'b0110, 4'b1111, 4'b0001, 4'b0011, 4'b0111};
        set_alu(4'd0, 32'h0, 32'h0, 32'h4, 1'b1);
        bus.mem_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.func3    = f3s[i];
            bus.byte_enb = bes[i];
            #1;
            total++;
            if (bus.valid !== 1'b0 || bus.wb_data !== 32'h0) begin
                bad++;
                $display("FAIL illegal[%0d]: wb=%h valid=%b want 0/0", i, bus.wb_data, bus.valid);
            end
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_reset_write();
        set_alu(4'd0, 32'h0, 32'h0, 32'hC, 1'b1);
        rst = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_read  = 1'b1;
        bus.byte_enb  = 4'b1111;
        bus.func3     = 3'b010;
        bus.w_dat     = 32'hDEAD_BEEF;
        #1;
        total++;
        if (bus.wb_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_read: wb=%h want 00000000", bus.wb_data);
        end
        tick();
        rst = 1'b0;
        bus.mem_write  = 1'b0;
        bus.debug_addr = 12'h00C;
        #1;
        total++;
        if (bus.debug_data !== ref_mem[3] || bus.wb_data !== ref_mem[3]) begin
            bad++;
            $display("FAIL rst_write: dbg=%h wb=%h want %h", bus.debug_data, bus.wb_data, ref_mem[3]);
        end
        bus.mem_read = 1'b0;
    endtask

    task automatic test_random_mem();
        logic [9:0]  idx, didx;
        logic [31:0] w, d;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic        v;
        logic [3:0]  masks [8];
        masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0000};
        rst = 1'b0;
        bus.mem_read = 1'b0;
        for (int i = 16; i < 48; i++) begin
            set_addr(10'(i));
            w = $urandom;
            bus.mem_write = 1'b1;
            bus.byte_enb  = 4'b1111;
            bus.w_dat     = w;
            tick();
            ref_mem[i] = w;
        end
        bus.mem_write = 1'b0;
        for (int n = 0; n < 300; n++) begin
            idx  = 10'($urandom_range(16, 47));
            didx = 10'($urandom_range(16, 47));
            rst  = ($urandom_range(0, 7) == 0);
            set_addr(idx);
            bus.debug_addr = {didx, 2'($urandom_range(0, 3))};
            bus.mem_read   = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                // write cycle: a full-word read of the same word sees old data
                be = 4'($urandom_range(0, 15));
                w  = $urandom;
                bus.mem_write = 1'b1;
                bus.byte_enb  = be;
                bus.w_dat     = w;
                bus.func3     = 3'b010;
                load_ref(3'b010, be, rst ? 32'h0 : ref_mem[idx], d, v);
                #1;
                total++;
                if (bus.wb_data !== d || bus.valid !== v) begin
                    bad++;
                    $display("FAIL rmem_rbw idx=%0d be=%b rst=%b: wb=%h v=%b want %h/%b",
                             idx, be, rst, bus.wb_data, bus.valid, d, v);
                end
                tick();
                if (!rst)
                    for (int k = 0; k < 4; k++)
                        if (be[k]) ref_mem[idx][8*k +: 8] = w[8*k +: 8];
                bus.mem_write = 1'b0;
            end else begin
                be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : masks[$urandom_range(0, 7)];
                f3 = 3'($urandom_range(0, 7));
                bus.byte_enb = be;
                bus.func3    = f3;
                load_ref(f3, be, rst ? 32'h0 : ref_mem[idx], d, v);
                #1;
                total++;
                if (bus.wb_data !== d || bus.valid !== v) begin
                    bad++;
                    $display("FAIL rmem_load idx=%0d f3=%b be=%b rst=%b: wb=%h v=%b want %h/%b",
                             idx, f3, be, rst, bus.wb_data, bus.valid, d, v);
                end
                tick();
            end
            total++;
            if (bus.debug_data !== ref_mem[didx]) begin
                bad++;
                $display("FAIL rmem_debug idx=%0d: got %h want %h", didx, bus.debug_data, ref_mem[didx]);
            end
        end
        rst = 1'b0;
        bus.mem_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_alu(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.mem_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.byte_enb   = 4'b0000;
        bus.w_dat      = 32'h0;
        bus.func3      = 3'b000;
        bus.debug_addr = 12'h0;
        tick();
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_word_store();
        test_byte_store();
        test_illegal();
        test_reset_write();
        test_random_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_mem_unit.md
ALU_MEM_UNIT -- requirements
Module: alu_mem_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: datapath width.
REQ-002 Parameter ADDR_WIDTH, default 12: memory byte-address width.
REQ-003 Parameter DEPTH, default 1024: memory depth in 32-bit words.
REQ-004 Port clk  in  1: the only clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, synchronous, active-high.
REQ-006 Port alu_ctrl  in  4: ALU operation select.
REQ-007 Port alu_src  in  1: operand B select; 0 = src2, 1 = sign_ext.
REQ-008 Port src1 / src2  in  32 each: register operands.
REQ-009 Port sign_ext  in  32: sign-extended immediate.
REQ-010 Port results  out  32: ALU result; also the memory byte address.
REQ-011 Port zero  out  1: high when results == 0.
REQ-012 Port res_last_bit  out  1: equals results[0].
REQ-013 Port mem_write  in  1; mem_read  in  1: memory write enable and read enable.
REQ-014 Port byte_enb  in  4: lane mask for stores and loads; bit i = byte i.
REQ-015 Port w_dat  in  32: store data, already lane-aligned.
REQ-016 Port func3  in  3: load type.
REQ-017 Port wb_data  out  32: extended load result; valid  out  1: load legal.
REQ-018 Port debug_addr  in  12; debug_data  out  32: side read port.

Function
REQ-019 ALU is combinational. B = alu_src ? sign_ext : src2. Operations by alu_ctrl:
- 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR
- 0101 SLL, 0110 SRL, 0111 SRA, each using B[4:0] as shift amount
- 1000 SLT (signed), 1001 SLTU (unsigned); result is 32'h1 if true, else 0
- all other codes: result 0
REQ-020 ADD and SUB wrap modulo 2^32; no overflow flag.
REQ-021 Memory is DEPTH words of 32 bits. Word index = address[ADDR_WIDTH-1:2]; address bits above ADDR_WIDTH are ignored.
REQ-022 Write: on the clock edge with mem_write=1 and rst=0, each byte lane i with byte_enb[i]=1 takes w_dat[8i+7:8i] at word results[11:2]. Other lanes are unchanged.
REQ-023 Read is combinational (zero latency): r_dat = mem[results[11:2]] when mem_read=1 and rst=0, otherwise 0.
REQ-024 A read of the word being written in the same cycle returns the old contents; the new contents are visible after the edge.
REQ-025 debug_data = mem[debug_addr[11:2]], combinational, independent of mem_read and rst.
REQ-026 Byte reader (combinational) selects from r_dat using byte_enb:
- LB 000 / LBU 100: byte_enb must be one-hot; the selected byte is sign- or zero-extended.
- LH 001 / LHU 101: byte_enb must be 0011 or 1100; the selected half is sign- or zero-extended.
- LW 010: byte_enb must be 1111; the whole word is passed through.
REQ-027 valid=1 only for a legal func3/byte_enb pair in REQ-026; otherwise valid=0 and wb_data=0.
REQ-028 func3 values 011, 110 and 111 give valid=0 and wb_data=0.

Reset
REQ-029 While rst=1: writes are inhibited and r_dat is forced to 0, so wb_data=0 and valid still follows REQ-026 to REQ-028.
REQ-030 Reset does not clear memory contents; contents at power-up are undefined.
REQ-031 ALU outputs are purely combinational and are unaffected by rst.
REQ-032 Reset asserted during a write cycle cancels that write.

Structure
REQ-033 A shared package holds DATA_WIDTH, the alu_ctrl encodings and the func3 load encodings.
REQ-034 The memory is one sub-module, bram32. The ALU and byte-reader logic are written inline in alu_mem_unit.
REQ-035 bram32 is inferable as block RAM: one synchronous byte-enabled write port, one asynchronous read port, one debug read port.

Verification
REQ-036 ADD: src1=5, src2=3, alu_src=0 -> results=8, zero=0, res_last_bit=0.
REQ-037 SLT and SUB:
- SLT with src1=FFFFFFFF, src2=1 -> results=1, res_last_bit=1.
- SLTU with the same operands -> results=0, zero=1.
- SUB with 5,5 -> zero=1.
REQ-038 Word store and load:
- ADD with sign_ext=C, src1=0, alu_src=1; mem_write=1, byte_enb=1111, w_dat=0000000A, one edge.
- Then debug_addr=00C -> debug_data=0000000A.
- Then mem_read=1, func3=010 -> wb_data=0000000A, valid=1.
REQ-039 Byte store and load:
- Store to address 4 with byte_enb=0010, w_dat=00008000.
- LB with byte_enb=0010 -> wb_data=FFFFFF80, valid=1.
- LBU with the same mask -> wb_data=00000080.
- Word 4 other lanes are unchanged.
REQ-040 Illegal loads: func3=001 with byte_enb=0110, or func3=011 -> valid=0, wb_data=0.
REQ-041 Reset during write: mem_write=1 with rst=1 at the edge -> the target word is unchanged; r_dat=0 while rst=1.
